// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment display controller: hex or decimal display of a software
// register, with per-digit blanking, blink, and an iterative double-dabble converter.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_W      = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  input  logic [31:0]             slave_writedata,
  output logic [31:0]             slave_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_DEC = pow10(NUM_DIGITS) - 64'd1;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [31:0]           value_q, value_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  en_q, en_d, blink_q, blink_d, dec_q, dec_d;
  logic [CNT_W-1:0]      blinkCnt_q, blinkCnt_d;
  logic                  blinkPhase_q, blinkPhase_d;

  state_t                state_q;
  logic [BIN_W-1:0]      bin_q;
  logic [BCD_W-1:0]      scratch_q, scratch_d, result_q;
  logic [STEP_W-1:0]     step_q;
  logic                  ovf_q, ovfPend_q;

  logic                  wrValue, wrBlank, wrCtrl, startReq, blinkArm, startOvf;
  logic [BIN_W-1:0]      startVal;
  logic [BCD_W-1:0]      adj;
  logic [3:0]            nib, shownNib;

  assign wrValue  = slave_write && (slave_address == 2'd0);
  assign wrBlank  = slave_write && (slave_address == 2'd1);
  assign wrCtrl   = slave_write && (slave_address == 2'd2);
  assign blinkArm = wrCtrl && !blink_q && slave_writedata[1];

  // Conversion starts on a VALUE write in decimal mode or on switching into decimal mode.
  assign startReq = (wrValue && dec_q) || (wrCtrl && !dec_q && slave_writedata[2]);
  assign startVal = wrValue ? slave_writedata[BIN_W-1:0] : value_q[BIN_W-1:0];
  assign startOvf = {{(64-BIN_W){1'b0}}, startVal} > MAX_DEC;

  always_comb begin
    value_d = wrValue ? slave_writedata : value_q;
    blank_d = wrBlank ? slave_writedata[NUM_DIGITS-1:0] : blank_q;
    en_d    = wrCtrl ? slave_writedata[0] : en_q;
    blink_d = wrCtrl ? slave_writedata[1] : blink_q;
    dec_d   = wrCtrl ? slave_writedata[2] : dec_q;
  end

  // Arming blink restarts the half-period so the display is visible right away.
  always_comb begin
    blinkCnt_d   = blinkCnt_q + CNT_W'(1);
    blinkPhase_d = blinkPhase_q;
    if (blinkArm) begin
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b0;
    end else if (blinkCnt_q == CNT_W'(BLINK_DIV - 1)) begin
      blinkCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q      <= '0;
      blank_q      <= '0;
      en_q         <= 1'b0;
      blink_q      <= 1'b0;
      dec_q        <= 1'b0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      value_q      <= value_d;
      blank_q      <= blank_d;
      en_q         <= en_d;
      blink_q      <= blink_d;
      dec_q        <= dec_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  always_comb begin
    adj = '0;
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = scratch_q[4*i +: 4];
      adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    scratch_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  end

  // Result and OVF are only committed on the final step, so the display never shows partial BCD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      result_q  <= '0;
      step_q    <= '0;
      ovf_q     <= 1'b0;
      ovfPend_q <= 1'b0;
    end else if (startReq) begin
      state_q   <= SHIFT;
      bin_q     <= startVal;
      scratch_q <= '0;
      step_q    <= '0;
      ovfPend_q <= startOvf;
    end else if (state_q == SHIFT) begin
      scratch_q <= scratch_d;
      bin_q     <= bin_q << 1;
      step_q    <= step_q + STEP_W'(1);
      if (step_q == STEP_W'(BIN_W - 1)) begin
        result_q <= scratch_d;
        ovf_q    <= ovfPend_q;
        state_q  <= IDLE;
      end
    end
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        2'd0: slave_readdata = value_q;
        2'd1: slave_readdata = 32'(blank_q);
        2'd2: slave_readdata = {29'd0, dec_q, blink_q, en_q};
        default: slave_readdata = {30'd0, ovf_q, state_q == SHIFT};
      endcase
    end
  end

  always_comb begin
    hex_out  = '1;
    shownNib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shownNib = dec_q ? result_q[4*i +: 4] : value_q[4*i +: 4];
      if (!en_q || (blink_q && blinkPhase_q) || blank_q[i])
        hex_out[7*i +: 7] = 7'b1111111;
      else if (dec_q && ovf_q)
        hex_out[7*i +: 7] = 7'b0111111;
      else
        hex_out[7*i +: 7] = seg7(shownNib);
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: a cycle-level reference model pushes expected
// display/readdata values, and a negedge monitor pops and compares them.
module tb_hex_display_ctrl;
  localparam int ND = 6;
  localparam int BW = 20;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    addr = '0;
  logic          rd = 1'b0, wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [7*ND-1:0] hex;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .slave_address(addr), .slave_read(rd), .slave_write(wr),
    .slave_writedata(wdata), .slave_readdata(rdata), .hex_out(hex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           cycle;
    bit           isRead;
    logic [7*ND-1:0] hexExp;
    logic [31:0]  rdExp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state, kept in plain spec terms: register contents, displayed decimal
  // number, cycles left in the current conversion and the cycle the blink timebase restarted.
  bit          modelValid = 0;
  logic [31:0] mValue;
  logic [5:0]  mBlank;
  bit          mEn, mBlink, mDec, mOvf;
  int          mResult, mPend, mBusyLeft, mBlinkStart;

  function automatic int pow10(int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7*ND-1:0] expectHex();
    logic [7*ND-1:0] h;
    bit ph;
    int dig;
    ph = (((cyc - mBlinkStart) / BD) % 2) == 1;
    for (int i = 0; i < ND; i++) begin
      if (!mEn || (mBlink && ph) || mBlank[i]) h[7*i +: 7] = 7'h7F;
      else if (mDec && mOvf) h[7*i +: 7] = 7'h3F;
      else begin
        dig = mDec ? (mResult / pow10(i)) % 10 : int'((mValue >> (4*i)) & 32'hF);
        h[7*i +: 7] = segTab[dig];
      end
    end
    return h;
  endfunction

  function automatic logic [31:0] expectRead(logic [1:0] a);
    case (a)
      2'd0: return mValue;
      2'd1: return {26'd0, mBlank};
      2'd2: return {29'd0, mDec, mBlink, mEn};
      default: return {30'd0, mOvf, mBusyLeft > 0};
    endcase
  endfunction

  task automatic modelEdge(bit w, logic [1:0] a, logic [31:0] d, bit rst);
    bit start;
    if (rst) begin
      mValue = '0; mBlank = '0; mEn = 0; mBlink = 0; mDec = 0; mOvf = 0;
      mResult = 0; mPend = 0; mBusyLeft = 0; mBlinkStart = cyc; modelValid = 1;
      return;
    end
    start = w && ((a == 2'd0 && mDec) || (a == 2'd2 && !mDec && d[2]));
    if (start) begin
      mPend = (a == 2'd0) ? int'(d[BW-1:0]) : int'(mValue[BW-1:0]);
      mBusyLeft = BW;
    end else if (mBusyLeft > 0) begin
      mBusyLeft--;
      if (mBusyLeft == 0) begin
        mResult = mPend;
        mOvf = mPend > pow10(ND) - 1;
      end
    end
    if (w) begin
      case (a)
        2'd0: mValue = d;
        2'd1: mBlank = d[5:0];
        2'd2: begin
          if (!mBlink && d[1]) mBlinkStart = cyc;
          {mDec, mBlink, mEn} = d[2:0];
        end
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive inputs, queue what the DUT must show this cycle, advance the model.
  task automatic applyStimulus(bit w, bit r, logic [1:0] a, logic [31:0] d, bit rst);
    exp_t e;
    wr = w; rd = r; addr = a; wdata = d; rst_n = !rst;
    if (modelValid) begin
      e.cycle = cyc; e.isRead = 0; e.hexExp = expectHex(); e.rdExp = '0;
      sb.push_back(e);
      if (r) begin
        e.isRead = 1; e.rdExp = expectRead(a);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    modelEdge(w, a, d, rst);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 2'd3, '0, 0);
  endtask

  task automatic checkOutput(exp_t e);
    checks++;
    if (e.cycle != cyc) begin
      failures++;
      $display("[TB] FAIL stale_entry cycle=%0d now=%0d", e.cycle, cyc);
    end else if (e.isRead) begin
      if (rdata !== e.rdExp) begin
        failures++;
        $display("[TB] FAIL readdata cycle=%0d addr=%0d got=%h want=%h", cyc, addr, rdata, e.rdExp);
      end
    end else if (hex !== e.hexExp) begin
      failures++;
      $display("[TB] FAIL hex_out cycle=%0d got=%h want=%h", cyc, hex, e.hexExp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cycle <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    logic [31:0] d;
    bit w, r;
    logic [1:0] a;
    applyStimulus(0, 0, 2'd0, '0, 1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 2'(k), '0, 0);

    applyStimulus(1, 0, 2'd2, 32'h1, 0);
    applyStimulus(1, 0, 2'd0, 32'h00AB_CDEF, 0);
    applyStimulus(0, 1, 2'd0, '0, 0);
    applyStimulus(1, 0, 2'd0, 32'd123456, 0);
    applyStimulus(1, 1, 2'd2, 32'h5, 0);
    idle(22);
    applyStimulus(1, 0, 2'd0, 32'd1000000, 0);
    idle(22);
    applyStimulus(1, 0, 2'd0, 32'd42, 0);
    idle(22);
    applyStimulus(1, 0, 2'd0, 32'd999999, 0);
    idle(4);
    applyStimulus(1, 0, 2'd0, 32'd7, 0);
    idle(22);
    applyStimulus(1, 0, 2'd2, 32'h7, 0);
    idle(12);
    applyStimulus(1, 0, 2'd1, 32'h3, 0);
    idle(12);
    applyStimulus(1, 0, 2'd0, 32'd555, 0);
    idle(5);
    applyStimulus(0, 0, 2'd0, '0, 1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 2'(k), '0, 0);

    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 99) == 0) applyStimulus(0, 0, 2'd0, '0, 1);
      else if ($urandom_range(0, 29) == 0) idle(24);
      else begin
        w = $urandom_range(0, 7) == 0;
        r = $urandom_range(0, 1) == 1;
        a = 2'($urandom_range(0, 3));
        d = $urandom();
        if (a == 2'd0 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 999999);
        if (a == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        applyStimulus(w, r, a, d, 0);
      end
    end
    idle(2);
    wr = 0; rd = 0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
